// File: rtl/rst_pkg.sv
// ---------------------------------------------------------------------------
// rst_pkg
// Shared definitions for the 6502 reset sequencer:
//   - sequencer state encoding
//   - reset-cause codes reported on rst_cause
//   - saturating 8-bit increment used for the reset counter
// ---------------------------------------------------------------------------
package rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD        = 2'b00,
    ST_WAIT_MEM    = 2'b01,
    ST_WAIT_PERIPH = 2'b10,
    ST_RUN         = 2'b11
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_delay_cnt.sv
// ---------------------------------------------------------------------------
// rst_delay_cnt
// Loadable down-counter with decrement enable and a zero flag.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (counter -> RST_VAL)
//   load_i     in   load load_val_i (has priority over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one
//   zero_o     out  counter currently equals zero
// ---------------------------------------------------------------------------
module rst_delay_cnt
  import rst_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int RST_VAL   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: load wins, then decrement, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_WIDTH'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq
// Reset sequencer for the 6502 system. Releases memory, then peripherals,
// then the CPU core, with spacing counted in clk_enable cycles. Button or
// watchdog requests restart the sequence from HOLD at any time.
// Ports:
//   clk          in   system clock
//   async_reset  in   asynchronous active-high reset
//   clk_enable   in   CPU phase enable; delay counting only when high
//   btn_reset    in   button reset request (level, synchronous)
//   wdt_req      in   watchdog reset request (pulse, synchronous)
//   mem_reset    out  reset to memory subsystem (active high)
//   periph_reset out  reset to peripherals (active high)
//   cpu_reset    out  reset to 6502 core (active high)
//   rst_done     out  sequence complete, system running
//   rst_cause    out  cause of last reset (00 POR, 01 button, 10 watchdog)
//   rst_count    out  saturating count of non-POR resets
// ---------------------------------------------------------------------------
module reset_seq
  import rst_pkg::*;
#(
  parameter int HOLD_CYCLES  = 8,
  parameter int MEM_DELAY    = 4,
  parameter int PERIPH_DELAY = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       clk_enable,
  input  logic       btn_reset,
  input  logic       wdt_req,
  output logic       mem_reset,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       rst_done,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam logic [CNT_WIDTH-1:0] HOLD_RELOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MEM_RELOAD    = CNT_WIDTH'(MEM_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIPH_RELOAD = CNT_WIDTH'(PERIPH_DELAY - 1);

  rst_state_e state_q, state_d;
  logic       mem_q, mem_d;
  logic       periph_q, periph_d;
  logic       cpu_q, cpu_d;
  logic       done_q, done_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] count_q, count_d;
  logic       req_prev_q;

  logic                 req_s;
  logic                 cnt_load_s;
  logic [CNT_WIDTH-1:0] cnt_load_val_s;
  logic                 cnt_dec_s;
  logic                 cnt_zero_s;

  assign req_s = btn_reset | wdt_req;

  rst_delay_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .RST_VAL   (HOLD_CYCLES - 1)
  ) u_cnt (
    .clk        (clk),
    .rst        (async_reset),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_load_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state, output and counter-control logic; a request overrides expiry.
  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    periph_d       = periph_q;
    cpu_d          = cpu_q;
    done_d         = done_q;
    cause_d        = cause_q;
    count_d        = count_q;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = HOLD_RELOAD;
    cnt_dec_s      = 1'b0;

    if (req_s) begin
      state_d        = ST_HOLD;
      cnt_load_s     = 1'b1;
      cnt_load_val_s = HOLD_RELOAD;
      mem_d          = 1'b1;
      periph_d       = 1'b1;
      cpu_d          = 1'b1;
      done_d         = 1'b0;
      cause_d        = btn_reset ? CAUSE_BTN : CAUSE_WDT;
      // A held button restarts HOLD each cycle but counts only once.
      if (!req_prev_q) begin
        count_d = sat_inc8(count_q);
      end else begin
        count_d = count_q;
      end
    end else if (clk_enable && (state_q != ST_RUN)) begin
      if (cnt_zero_s) begin
        case (state_q)
          ST_HOLD: begin
            state_d        = ST_WAIT_MEM;
            mem_d          = 1'b0;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = MEM_RELOAD;
          end
          ST_WAIT_MEM: begin
            state_d        = ST_WAIT_PERIPH;
            periph_d       = 1'b0;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = PERIPH_RELOAD;
          end
          ST_WAIT_PERIPH: begin
            state_d = ST_RUN;
            cpu_d   = 1'b0;
            done_d  = 1'b1;
          end
          default: begin
            // Unreachable encoding: fall back to a full reset sequence.
            state_d        = ST_HOLD;
            mem_d          = 1'b1;
            periph_d       = 1'b1;
            cpu_d          = 1'b1;
            done_d         = 1'b0;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = HOLD_RELOAD;
          end
        endcase
      end else begin
        cnt_dec_s = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, output and bookkeeping registers.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q    <= ST_HOLD;
      mem_q      <= 1'b1;
      periph_q   <= 1'b1;
      cpu_q      <= 1'b1;
      done_q     <= 1'b0;
      cause_q    <= CAUSE_POR;
      count_q    <= 8'd0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      periph_q   <= periph_d;
      cpu_q      <= cpu_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      req_prev_q <= req_s;
    end
  end

  assign mem_reset    = mem_q;
  assign periph_reset = periph_q;
  assign cpu_reset    = cpu_q;
  assign rst_done     = done_q;
  assign rst_cause    = cause_q;
  assign rst_count    = count_q;

endmodule

// File: tb/tb_reset_seq.sv
module tb_reset_seq;

  localparam int HOLD  = 8;
  localparam int MEMD  = 4;
  localparam int PERD  = 4;
  localparam int TOTAL = HOLD + MEMD + PERD;

  logic       clk;
  logic       async_reset;
  logic       clk_enable;
  logic       btn_reset;
  logic       wdt_req;
  logic       mem_reset;
  logic       periph_reset;
  logic       cpu_reset;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int n_cmp;
  int n_err;

  // Reference model: enabled edges since the sequence (re)started.
  int m_ticks;
  int m_cause;
  int m_count;
  bit m_prev;

  reset_seq #(
    .HOLD_CYCLES  (HOLD),
    .MEM_DELAY    (MEMD),
    .PERIPH_DELAY (PERD),
    .CNT_WIDTH    (8)
  ) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .clk_enable   (clk_enable),
    .btn_reset    (btn_reset),
    .wdt_req      (wdt_req),
    .mem_reset    (mem_reset),
    .periph_reset (periph_reset),
    .cpu_reset    (cpu_reset),
    .rst_done     (rst_done),
    .rst_cause    (rst_cause),
    .rst_count    (rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [7:0] e_mem, e_per, e_cpu, e_done;
    e_mem  = (m_ticks < HOLD) ? 8'd1 : 8'd0;
    e_per  = (m_ticks < HOLD + MEMD) ? 8'd1 : 8'd0;
    e_cpu  = (m_ticks < TOTAL) ? 8'd1 : 8'd0;
    e_done = (m_ticks < TOTAL) ? 8'd0 : 8'd1;
    chk("mem_reset",    {7'd0, mem_reset},    e_mem);
    chk("periph_reset", {7'd0, periph_reset}, e_per);
    chk("cpu_reset",    {7'd0, cpu_reset},    e_cpu);
    chk("rst_done",     {7'd0, rst_done},     e_done);
    chk("rst_cause",    {6'd0, rst_cause},    8'(m_cause));
    chk("rst_count",    rst_count,            8'(m_count));
  endtask

  task automatic model_reset();
    m_ticks = 0;
    m_cause = 0;
    m_count = 0;
    m_prev  = 1'b0;
  endtask

  // One clock edge with the given inputs, then model update and check.
  task automatic step(input bit en, input bit btn, input bit wdt);
    bit req;
    clk_enable = en;
    btn_reset  = btn;
    wdt_req    = wdt;
    @(posedge clk);
    req = btn | wdt;
    if (req) begin
      m_ticks = 0;
      m_cause = btn ? 1 : 2;
      if (!m_prev) m_count = (m_count >= 255) ? 255 : m_count + 1;
    end else if (en && m_ticks < TOTAL) begin
      m_ticks = m_ticks + 1;
    end
    m_prev = req;
    #1;
    chk_model();
  endtask

  task automatic por();
    async_reset = 1'b1;
    clk_enable  = 1'b1;
    btn_reset   = 1'b0;
    wdt_req     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_model();
    async_reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();

    // Power-on with clk_enable constantly high: releases at edges 8/12/16.
    por();
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 7)  chk("mem_before_8",  {7'd0, mem_reset},    8'd1);
      if (i == 8)  chk("mem_at_8",      {7'd0, mem_reset},    8'd0);
      if (i == 11) chk("per_before_12", {7'd0, periph_reset}, 8'd1);
      if (i == 12) chk("per_at_12",     {7'd0, periph_reset}, 8'd0);
      if (i == 15) chk("cpu_before_16", {7'd0, cpu_reset},    8'd1);
      if (i == 16) chk("done_at_16",    {7'd0, rst_done},     8'd1);
    end

    // clk_enable on every other edge: releases at edges 16/24/32.
    por();
    for (int i = 1; i <= 34; i++) begin
      step(i % 2 == 0, 1'b0, 1'b0);
      if (i == 15) chk("half_mem_15", {7'd0, mem_reset}, 8'd1);
      if (i == 16) chk("half_mem_16", {7'd0, mem_reset}, 8'd0);
      if (i == 32) chk("half_done_32", {7'd0, rst_done}, 8'd1);
    end

    // Watchdog pulse during WAIT_PERIPH, then a full re-sequence.
    por();
    for (int i = 1; i <= 13; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("wdt_mem_reasserted", {7'd0, mem_reset}, 8'd1);
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 1'b0);
    chk("wdt_cause", {6'd0, rst_cause}, 8'd2);
    chk("wdt_count", rst_count, 8'd1);

    // Button held for 20 cycles in RUN: counted once.
    por();
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 1'b0);
    chk("btn_count", rst_count, 8'd1);

    // Button and watchdog on the same edge: button wins.
    step(1'b1, 1'b1, 1'b1);
    chk("both_cause", {6'd0, rst_cause}, 8'd1);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0);

    // Async reset during WAIT_MEM takes effect without a clock edge.
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0);
    #2;
    async_reset = 1'b1;
    #1;
    model_reset();
    chk_model();
    @(posedge clk);
    #1;
    async_reset = 1'b0;

    // Randomized traffic with occasional requests and gated enables.
    for (int i = 0; i < 400; i++) begin
      bit btn_v;
      btn_v = ($urandom_range(0, 19) == 0) ? ~btn_reset : btn_reset;
      step($urandom_range(0, 3) != 0, btn_v, $urandom_range(0, 24) == 0);
    end
    step(1'b1, 1'b0, 1'b0);

    // Saturation of the reset counter at 255.
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("count_saturated", rst_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Reset sequencer for the 6502 system. It sits downstream of the power-on reset generator and takes the system-wide reset plus later reset requests (front-panel button, watchdog). It releases memory, peripherals and the CPU core in a fixed order, with programmable spacing counted in enabled clock cycles, and records the cause of the most recent reset.

## Interface
Parameters:
- HOLD_CYCLES, 8: enabled cycles all resets stay asserted after entry to HOLD (minimum 1)
- MEM_DELAY, 4: enabled cycles from mem_reset release to periph_reset release (minimum 1)
- PERIPH_DELAY, 4: enabled cycles from periph_reset release to cpu_reset release (minimum 1)
- CNT_WIDTH, 8: delay counter width; must hold max(HOLD_CYCLES, MEM_DELAY, PERIPH_DELAY) − 1

Ports:
- clk  in  1  system clock
- async_reset  in  1  asynchronous, active-high reset (driven by sync_reset of the power-on generator)
- clk_enable  in  1  CPU phase enable; delay counters advance only when high
- btn_reset  in  1  button reset request, level, already synchronous to clk
- wdt_req  in  1  watchdog reset request, single-cycle pulse, synchronous
- mem_reset  out  1  active-high reset to memory subsystem
- periph_reset  out  1  active-high reset to peripherals
- cpu_reset  out  1  active-high reset to 6502 core
- rst_done  out  1  high when the sequence is complete and the system is running
- rst_cause  out  2  cause of last reset: 00 POR, 01 button, 10 watchdog, 11 reserved
- rst_count  out  8  saturating count of non-POR resets

## Operation
- Clock is clk. Reset is asynchronous and active-high: async_reset. It sets state HOLD, cnt = HOLD_CYCLES−1, mem_reset/periph_reset/cpu_reset = 1, rst_done = 0, rst_cause = 00, rst_count = 0.
- States: HOLD, WAIT_MEM, WAIT_PERIPH, RUN.
- On each edge with clk_enable = 1, outside RUN:
  - If cnt == 0, advance state and reload cnt.
  - Otherwise, cnt decrements.
- Transitions:
  - HOLD→WAIT_MEM: mem_reset←0, cnt←MEM_DELAY−1.
  - WAIT_MEM→WAIT_PERIPH: periph_reset←0, cnt←PERIPH_DELAY−1.
  - WAIT_PERIPH→RUN: cpu_reset←0, rst_done←1.
- RUN is held indefinitely. The counter is idle in RUN.
- Request = btn_reset | wdt_req. Requests are sampled on every clk edge, regardless of clk_enable. On a request:
  - state←HOLD, cnt←HOLD_CYCLES−1.
  - All three resets←1, rst_done←0.
  - rst_cause←01 if btn_reset, else 10.
  - rst_count increments and saturates at 255.
- A held btn_reset re-enters HOLD every cycle. This stretches the reset; rst_count increments once per rising edge of the request, not once per cycle.
- Request beats counter expiry in the same cycle.
- btn_reset and wdt_req in the same cycle: cause 01, count +1.
- A request in any state, including mid-sequence, restarts from HOLD.
- Outputs are registered only. No combinational paths from inputs to outputs.

## Timing
- With clk_enable constantly 1 and no requests:
  - mem_reset falls on the HOLD_CYCLES-th edge after async_reset deasserts.
  - periph_reset falls MEM_DELAY edges after that.
  - cpu_reset and rst_done change on the same edge, PERIPH_DELAY edges after periph_reset falls.
- With clk_enable low, all delays stall. Only enabled edges count.
- Request to reset assertion: 1 clk edge, independent of clk_enable.
- Release order mem → periph → cpu is guaranteed. No two releases happen on the same edge.
- async_reset mid-sequence returns all outputs to reset values immediately (asynchronously). rst_count clears.

## Structure
- Shared package/include `rst_pkg` holds:
  - state encoding constants (HOLD, WAIT_MEM, WAIT_PERIPH, RUN)
  - cause codes (CAUSE_POR, CAUSE_BTN, CAUSE_WDT)
- One sub-module, `rst_delay_cnt`, is natural: a loadable down-counter with enable and a zero flag, width CNT_WIDTH.
- Request edge detection and the cause/count registers stay in reset_seq.

## Test plan
Defaults apply: HOLD=8, MEM=4, PERIPH=4.
- Power-on, clk_enable = 1, async_reset released at edge 0 → mem_reset falls at edge 8, periph_reset at 12, cpu_reset and rst_done at 16; rst_cause = 00, rst_count = 0.
- clk_enable high every other cycle → the same releases occur at edges 16, 24, 32.
- wdt_req pulse during WAIT_PERIPH → all resets = 1 on the next edge, then a full 8/4/4 re-sequence; rst_cause = 10, rst_count = 1.
- btn_reset held for 20 cycles in RUN → resets held for all 20 cycles; mem_reset falls 8 edges after release; rst_count = 1, rst_cause = 01.
- btn_reset and wdt_req asserted in the same cycle → rst_cause = 01, rst_count +1.
- async_reset asserted during WAIT_MEM → all resets go to 1 immediately; rst_count = 0, rst_cause = 00.
